// File: rtl/ldm_scan_ctrl.sv
// ldm_scan_ctrl
// Row-scan controller for the LED dot-matrix panel. For each row it reads one
// word from the frame buffer, shifts it out MSB first on ldm_clk/ldm_data,
// latches it with the row address while the panel is blanked, and then lights
// the row for HOLD cycles. Rows are scanned continuously while en is high.
//
// Ports
//   clk, rstn        system clock, asynchronous active-low reset
//   en               scan enable (level); a running row always completes
//   fb_rd_en/_row    frame-buffer read strobe (1 cycle) and row index
//   fb_rd_data       row word, valid the cycle after fb_rd_en
//   fb_buf_sel       frame-buffer half on display
//   swap_req/ack     buffer-swap handshake, resolved at the end of a frame
//   frame_done       1-cycle pulse after the last row's on-time
//   busy             high whenever a scan is in progress
//   ldm_*            panel pins: shift clock, data, latch, OE (active-low), row
//
// Build option
//   LDM_SCAN_DOUBLE_BUF_EN  enables the swap handshake; without it swap_req
//                           is ignored and swap_ack/fb_buf_sel stay 0.
//
// All outputs come straight from flops; their next values are derived from
// the next state so each output lines up exactly with its state.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | not scanning, panel dark, row counter held at 0
// S_FETCH   | frame-buffer read strobe for the current row
// S_WAIT    | read data arrives and is loaded into the shift register
// S_SHIFT   | COLS bits out, each DIV cycles ldm_clk low then DIV high
// S_BLANK   | one dark cycle between shifting and latching
// S_LATCH   | row address updated, ldm_lat high for DIV cycles
// S_DISPLAY | row lit for HOLD cycles, then next row / frame end / idle

module ldm_scan_ctrl #(
    parameter int COLS = 16,
    parameter int ROWS = 16,
    parameter int DIV  = 2,
    parameter int HOLD = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    output logic            fb_rd_en,
    output logic [3:0]      fb_rd_row,
    input  logic [COLS-1:0] fb_rd_data,
    output logic            fb_buf_sel,
    input  logic            swap_req,
    output logic            swap_ack,
    output logic            frame_done,
    output logic            busy,
    output logic            ldm_clk,
    output logic            ldm_data,
    output logic            ldm_lat,
    output logic            ldm_oe_n,
    output logic [3:0]      ldm_addr
);

    localparam int TMAX = (HOLD > DIV) ? HOLD : DIV;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
    localparam int BW   = (COLS < 2) ? 1 : $clog2(COLS);

    localparam logic [TW-1:0] DIV_LD   = TW'(DIV - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(COLS - 1);
    localparam logic [3:0]    LAST_ROW = 4'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic            half, half_nxt;
    logic [BW-1:0]   bit_cnt, bit_nxt;
    logic [COLS-1:0] sh, sh_nxt;
    logic [3:0]      row, row_nxt;

    logic            rd_en_nxt, sel_nxt, ack_nxt, done_nxt, busy_nxt;
    logic            clk_nxt, data_nxt, lat_nxt, oe_n_nxt;
    logic [3:0]      rd_row_nxt, addr_nxt;

`ifndef LDM_SCAN_DOUBLE_BUF_EN
    logic swap_req_unused;
    assign swap_req_unused = swap_req;
`endif

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        half_nxt  = half;
        bit_nxt   = bit_cnt;
        sh_nxt    = sh;
        row_nxt   = row;
        addr_nxt  = ldm_addr;
        sel_nxt   = fb_buf_sel;
        ack_nxt   = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                row_nxt = 4'd0;
                if (en) state_nxt = S_FETCH;
            end
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT: begin
                sh_nxt    = fb_rd_data;
                tmr_nxt   = DIV_LD;
                half_nxt  = 1'b0;
                bit_nxt   = '0;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - 1'b1;
                end else begin
                    tmr_nxt = DIV_LD;
                    if (!half) begin
                        half_nxt = 1'b1;
                    end else begin
                        // end of the high phase: ldm_clk falls, next bit
                        half_nxt = 1'b0;
                        sh_nxt   = sh << 1;
                        if (bit_cnt == LAST_BIT) state_nxt = S_BLANK;
                        else                     bit_nxt   = bit_cnt + 1'b1;
                    end
                end
            end
            S_BLANK: begin
                tmr_nxt   = DIV_LD;
                addr_nxt  = row;        // address moves only while dark
                state_nxt = S_LATCH;
            end
            S_LATCH: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - 1'b1;
                end else begin
                    tmr_nxt   = HOLD_LD;
                    state_nxt = S_DISPLAY;
                end
            end
            S_DISPLAY: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - 1'b1;
                end else begin
                    if (row == LAST_ROW) begin
                        row_nxt  = 4'd0;
                        done_nxt = 1'b1;
`ifdef LDM_SCAN_DOUBLE_BUF_EN
                        if (swap_req) begin
                            sel_nxt = ~fb_buf_sel;
                            ack_nxt = 1'b1;
                        end
`endif
                    end else begin
                        row_nxt = row + 4'd1;
                    end
                    if (en) begin
                        state_nxt = S_FETCH;
                    end else begin
                        row_nxt   = 4'd0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        rd_en_nxt  = (state_nxt == S_FETCH);
        rd_row_nxt = (state_nxt == S_FETCH) ? row_nxt : fb_rd_row;
        clk_nxt    = (state_nxt == S_SHIFT) && half_nxt;
        data_nxt   = (state_nxt == S_SHIFT) ? sh_nxt[COLS-1] : 1'b0;
        lat_nxt    = (state_nxt == S_LATCH);
        oe_n_nxt   = (state_nxt != S_DISPLAY);
        busy_nxt   = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            tmr        <= '0;
            half       <= 1'b0;
            bit_cnt    <= '0;
            sh         <= '0;
            row        <= 4'd0;
            fb_rd_en   <= 1'b0;
            fb_rd_row  <= 4'd0;
            fb_buf_sel <= 1'b0;
            swap_ack   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            ldm_clk    <= 1'b0;
            ldm_data   <= 1'b0;
            ldm_lat    <= 1'b0;
            ldm_oe_n   <= 1'b1;
            ldm_addr   <= 4'd0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            half       <= half_nxt;
            bit_cnt    <= bit_nxt;
            sh         <= sh_nxt;
            row        <= row_nxt;
            fb_rd_en   <= rd_en_nxt;
            fb_rd_row  <= rd_row_nxt;
            fb_buf_sel <= sel_nxt;
            swap_ack   <= ack_nxt;
            frame_done <= done_nxt;
            busy       <= busy_nxt;
            ldm_clk    <= clk_nxt;
            ldm_data   <= data_nxt;
            ldm_lat    <= lat_nxt;
            ldm_oe_n   <= oe_n_nxt;
            ldm_addr   <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_ldm_scan_ctrl.sv
// Self-checking bench for ldm_scan_ctrl. A small RAM model serves row words;
// expectations come from the panel-level rules: row period, captured serial
// words, latched address, lit time, frame-end pulses and the swap handshake.
// Works with or without LDM_SCAN_DOUBLE_BUF_EN.

module tb_ldm_scan_ctrl;

    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam int DIV  = 2;
    localparam int HOLD = 32;
    localparam int PERIOD = 1 + 1 + 2*DIV*COLS + 1 + DIV + HOLD;
`ifdef LDM_SCAN_DOUBLE_BUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif
    // {clk,data,lat,oe_n,addr[4],rd_en,rd_row[4],buf_sel,ack,frame_done,busy}
    localparam logic [16:0] RST_OUTS = 17'b0_0_0_1_0000_0_0000_0_0_0_0;

    logic            clk, rstn, en, swap_req;
    logic            fb_rd_en, fb_buf_sel, swap_ack, frame_done, busy;
    logic [3:0]      fb_rd_row, ldm_addr;
    logic [COLS-1:0] fb_rd_data;
    logic            ldm_clk, ldm_data, ldm_lat, ldm_oe_n;

    ldm_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .DIV(DIV), .HOLD(HOLD)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .fb_rd_en(fb_rd_en), .fb_rd_row(fb_rd_row), .fb_rd_data(fb_rd_data),
        .fb_buf_sel(fb_buf_sel), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_done(frame_done), .busy(busy),
        .ldm_clk(ldm_clk), .ldm_data(ldm_data), .ldm_lat(ldm_lat),
        .ldm_oe_n(ldm_oe_n), .ldm_addr(ldm_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [2][ROWS];
    initial fb_rd_data = '0;
    always_ff @(posedge clk) if (fb_rd_en) fb_rd_data <= mem[fb_buf_sel][fb_rd_row];

    int n_cmp = 0;
    int n_err = 0;
    bit exp_sel;
    logic [15:0] exp_word;

    int          period, nbits, oe_cnt, lat;
    logic [15:0] word;
    logic [3:0]  addr;
    bit          ghost, unstable, fd, ack, to;

    function automatic logic [16:0] outs();
        return {ldm_clk, ldm_data, ldm_lat, ldm_oe_n, ldm_addr, fb_rd_en,
                fb_rd_row, fb_buf_sel, swap_ack, frame_done, busy};
    endfunction

    // Observes one row starting from the sample where fb_rd_en is high and
    // stops at the next fetch or when the controller goes idle.
    task automatic scan_row(input int drop_at, output int o_period, output logic [15:0] o_word,
                            output int o_nbits, output logic [3:0] o_addr, output int o_oe,
                            output bit o_ghost, output bit o_unst, output bit o_fd,
                            output bit o_ack, output bit o_to);
        int n;
        logic pclk, pdata;
        logic [3:0] paddr;
        n = 0; o_period = 0; o_word = '0; o_nbits = 0; o_addr = '0; o_oe = 0;
        o_ghost = 0; o_unst = 0; o_fd = 0; o_ack = 0; o_to = 0;
        pclk = ldm_clk; pdata = ldm_data; paddr = ldm_addr;
        forever begin
            @(negedge clk);
            n++;
            if (n == drop_at) en = 1'b0;
            if (fb_rd_en || !busy) begin
                o_period = n; o_fd = frame_done; o_ack = swap_ack;
                break;
            end
            if (n > 4*PERIOD) begin
                o_to = 1; o_period = n;
                break;
            end
            if (ldm_clk && !pclk) begin
                o_word = {o_word[14:0], ldm_data};
                o_nbits++;
                if (ldm_data !== pdata) o_unst = 1;
            end
            if (ldm_clk && pclk && ldm_data !== pdata) o_unst = 1;
            if (ldm_lat) o_addr = ldm_addr;
            if (!ldm_oe_n) begin
                o_oe++;
                if (ldm_addr !== paddr || ldm_lat) o_ghost = 1;
            end
            pclk = ldm_clk; pdata = ldm_data; paddr = ldm_addr;
        end
    endtask

    task automatic wait_fetch(output int o_lat, output bit o_to);
        o_lat = 0; o_to = 0;
        do begin
            @(negedge clk);
            o_lat++;
        end while (!fb_rd_en && o_lat < 50);
        if (!fb_rd_en) o_to = 1;
    endtask

    task automatic test_reset();
        bit bad;
        rstn = 1'b0; en = 1'b0; swap_req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (outs() !== RST_OUTS) begin n_err++; $display("FAIL reset_outputs: got %b expected %b", outs(), RST_OUTS); end
        rstn = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || fb_rd_en || !ldm_oe_n) bad = 1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL idle_when_disabled: got activity=%0d expected 0", bad); end
    endtask

    task automatic test_scan();
        for (int r = 0; r < ROWS; r++) begin
            mem[0][r] = 16'hA5A5 ^ 16'(r);
            mem[1][r] = 16'($urandom);
        end
        exp_sel = 1'b0;
        en = 1'b1;
        wait_fetch(lat, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL first_fetch_timeout: got timeout=%0d expected 0", to); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL first_fetch_latency: got %0d expected 1", lat); end
        for (int f = 0; f < 2; f++) begin
            if (f == 1) for (int k = 0; k < ROWS; k++) mem[0][k] = 16'($urandom);
            for (int r = 0; r < ROWS; r++) begin
                n_cmp++; if (fb_rd_row !== 4'(r)) begin n_err++; $display("FAIL fetch_row f=%0d r=%0d: got %0d expected %0d", f, r, fb_rd_row, r); end
                exp_word = mem[exp_sel][r];
                scan_row(0, period, word, nbits, addr, oe_cnt, ghost, unstable, fd, ack, to);
                n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL row_timeout f=%0d r=%0d: got %0d expected 0", f, r, to); end
                n_cmp++; if (word !== exp_word) begin n_err++; $display("FAIL row_data f=%0d r=%0d: got %h expected %h", f, r, word, exp_word); end
                n_cmp++; if (nbits !== COLS) begin n_err++; $display("FAIL row_bits f=%0d r=%0d: got %0d expected %0d", f, r, nbits, COLS); end
                n_cmp++; if (addr !== 4'(r)) begin n_err++; $display("FAIL row_addr f=%0d r=%0d: got %0d expected %0d", f, r, addr, r); end
                n_cmp++; if (period !== PERIOD) begin n_err++; $display("FAIL row_period f=%0d r=%0d: got %0d expected %0d", f, r, period, PERIOD); end
                n_cmp++; if (oe_cnt !== HOLD) begin n_err++; $display("FAIL row_on_time f=%0d r=%0d: got %0d expected %0d", f, r, oe_cnt, HOLD); end
                n_cmp++; if (ghost !== 1'b0) begin n_err++; $display("FAIL ghosting f=%0d r=%0d: got %0d expected 0", f, r, ghost); end
                n_cmp++; if (unstable !== 1'b0) begin n_err++; $display("FAIL data_setup_hold f=%0d r=%0d: got %0d expected 0", f, r, unstable); end
                n_cmp++; if (fd !== (r == ROWS-1)) begin n_err++; $display("FAIL frame_done f=%0d r=%0d: got %0d expected %0d", f, r, fd, (r == ROWS-1)); end
                n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL no_req_ack f=%0d r=%0d: got %0d expected 0", f, r, ack); end
            end
        end
    endtask

    task automatic test_swap();
        bit req_at_end, exp_ack;
        int req_row;
        for (int f = 0; f < 3; f++) begin
            req_row = $urandom_range(1, ROWS-2);
            for (int r = 0; r < ROWS; r++) begin
                if ((f == 0 || f == 2) && r == req_row) swap_req = 1'b1;
                exp_word = mem[exp_sel][r];
                req_at_end = swap_req;
                scan_row(0, period, word, nbits, addr, oe_cnt, ghost, unstable, fd, ack, to);
                n_cmp++; if (word !== exp_word) begin n_err++; $display("FAIL swap_row_data f=%0d r=%0d: got %h expected %h", f, r, word, exp_word); end
                if (r == ROWS-1) begin
                    exp_ack = DBUF && req_at_end;
                    if (exp_ack) exp_sel = ~exp_sel;
                    n_cmp++; if (fd !== 1'b1) begin n_err++; $display("FAIL swap_frame_done f=%0d: got %0d expected 1", f, fd); end
                    n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL swap_ack f=%0d: got %0d expected %0d", f, ack, exp_ack); end
                    n_cmp++; if (fb_buf_sel !== exp_sel) begin n_err++; $display("FAIL buf_sel f=%0d: got %0d expected %0d", f, fb_buf_sel, exp_sel); end
                    if (DBUF && swap_ack) swap_req = 1'b0;
                end else begin
                    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL swap_ack_early f=%0d r=%0d: got %0d expected 0", f, r, ack); end
                end
            end
        end
        swap_req = 1'b0;
    endtask

    task automatic test_en_drop();
        bit bad;
        for (int r = 0; r <= 5; r++) begin
            exp_word = mem[exp_sel][r];
            scan_row((r == 5) ? $urandom_range(3, 60) : 0, period, word, nbits, addr, oe_cnt, ghost, unstable, fd, ack, to);
        end
        n_cmp++; if (period !== PERIOD) begin n_err++; $display("FAIL drop_period: got %0d expected %0d", period, PERIOD); end
        n_cmp++; if (word !== exp_word) begin n_err++; $display("FAIL drop_row_data: got %h expected %h", word, exp_word); end
        n_cmp++; if (addr !== 4'd5) begin n_err++; $display("FAIL drop_addr: got %0d expected 5", addr); end
        n_cmp++; if (oe_cnt !== HOLD) begin n_err++; $display("FAIL drop_on_time: got %0d expected %0d", oe_cnt, HOLD); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %0d expected 0", busy); end
        n_cmp++; if (ldm_oe_n !== 1'b1) begin n_err++; $display("FAIL drop_oe_n: got %0d expected 1", ldm_oe_n); end
        n_cmp++; if (fd !== 1'b0) begin n_err++; $display("FAIL drop_frame_done: got %0d expected 0", fd); end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || fb_rd_en || !ldm_oe_n) bad = 1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL drop_stays_idle: got activity=%0d expected 0", bad); end
        en = 1'b1;
        wait_fetch(lat, to);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL reenable_latency: got %0d expected 1", lat); end
        n_cmp++; if (fb_rd_row !== 4'd0) begin n_err++; $display("FAIL reenable_row: got %0d expected 0", fb_rd_row); end
        exp_word = mem[exp_sel][0];
        scan_row(0, period, word, nbits, addr, oe_cnt, ghost, unstable, fd, ack, to);
        n_cmp++; if (addr !== 4'd0) begin n_err++; $display("FAIL reenable_addr: got %0d expected 0", addr); end
        n_cmp++; if (word !== exp_word) begin n_err++; $display("FAIL reenable_data: got %h expected %h", word, exp_word); end
    endtask

    task automatic test_reset_mid();
        for (int r = 1; r < 9; r++) begin
            scan_row(0, period, word, nbits, addr, oe_cnt, ghost, unstable, fd, ack, to);
            n_cmp++; if (addr !== 4'(r)) begin n_err++; $display("FAIL pre_reset_addr r=%0d: got %0d expected %0d", r, addr, r); end
        end
        n_cmp++; if (fb_rd_row !== 4'd9) begin n_err++; $display("FAIL reset_row9_fetch: got %0d expected 9", fb_rd_row); end
        repeat ($urandom_range(70, 99)) @(negedge clk);
        n_cmp++; if (ldm_oe_n !== 1'b0) begin n_err++; $display("FAIL reset_in_display: got oe_n=%0d expected 0", ldm_oe_n); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (outs() !== RST_OUTS) begin n_err++; $display("FAIL mid_reset_outputs: got %b expected %b", outs(), RST_OUTS); end
        @(negedge clk);
        n_cmp++; if (outs() !== RST_OUTS) begin n_err++; $display("FAIL mid_reset_held: got %b expected %b", outs(), RST_OUTS); end
        exp_sel = 1'b0;
        rstn = 1'b1;
        wait_fetch(lat, to);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL post_reset_latency: got %0d expected 1", lat); end
        n_cmp++; if (fb_rd_row !== 4'd0) begin n_err++; $display("FAIL post_reset_row: got %0d expected 0", fb_rd_row); end
        exp_word = mem[exp_sel][0];
        scan_row(0, period, word, nbits, addr, oe_cnt, ghost, unstable, fd, ack, to);
        n_cmp++; if (word !== exp_word) begin n_err++; $display("FAIL post_reset_data: got %h expected %h", word, exp_word); end
        n_cmp++; if (period !== PERIOD) begin n_err++; $display("FAIL post_reset_period: got %0d expected %0d", period, PERIOD); end
        en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_swap();
        test_en_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
